// File: rtl/fb_pkg.sv
// Shared constants and types for the double-buffered OLED frame store.
package fb_pkg;

    // Default geometry: 96x64 panel, RGB565 pixels
    localparam int unsigned FB_WIDTH  = 96;
    localparam int unsigned FB_HEIGHT = 64;
    localparam int unsigned FB_DATA_W = 16;

    // Common RGB565 colours
    localparam logic [15:0] BLACK = 16'h0000;
    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] RED   = 16'hF800;

    // Clear engine states
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/fb_dp_ram.sv
// Simple dual-port RAM: one synchronous write port and one registered read
// port. Contents start at zero. The read port returns zero when rd_en is low.
module fb_dp_ram #(
    parameter  int unsigned DEPTH = 256,
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data selection ahead of the output register
    always_comb begin
        rdata_d = '0;
        if (rd_en) begin
            rdata_d = mem[raddr];
        end
    end

    // Registered read output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/frame_buffer_dbl.sv
// Double-buffered frame store. The renderer writes the back page while the
// display reads the front page; pages swap only on frame_sync, and a clear
// engine can fill the back page with one colour at one pixel per clock.
module frame_buffer_dbl
    import fb_pkg::*;
#(
    parameter  int unsigned WIDTH  = FB_WIDTH,
    parameter  int unsigned HEIGHT = FB_HEIGHT,
    parameter  int unsigned DATA_W = FB_DATA_W,
    localparam int unsigned DEPTH  = WIDTH * HEIGHT,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              clear_start,
    input  logic [DATA_W-1:0] clear_color,
    output logic              clear_busy,
    input  logic              swap_req,
    input  logic              frame_sync,
    output logic              swap_pending,
    output logic              front_page
);

    // Physical address is {page, pixel}; the RAM spans the full concatenated range
    localparam int unsigned        RAM_DEPTH = 1 << (ADDR_W + 1);
    localparam logic [ADDR_W:0]    DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0]  LAST_PIX  = ADDR_W'(DEPTH - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              front_q, front_d;
    logic              pend_q, pend_d;

    logic              wr_accept;
    logic              rd_in_range;
    logic              do_swap;
    logic              ram_we;
    logic [ADDR_W:0]   ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [ADDR_W:0]   ram_raddr;

    assign wr_accept   = wr_en && ready_q && ({1'b0, wr_addr} < DEPTH_X);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);

    // Clear engine next-state: latch colour on start, walk every pixel once
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    color_d = clear_color;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_PIX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        ready_d = !busy_d;
    end

    // Swap control: requests merge while pending, and a clear in progress holds the swap off
    always_comb begin
        do_swap = frame_sync && (pend_q || swap_req) && !busy_q;
        front_d = front_q;
        pend_d  = pend_q || swap_req;
        if (do_swap) begin
            front_d = !front_q;
            pend_d  = 1'b0;
        end
    end

    // Single RAM write port shared by the clear engine and the renderer; nothing is written during reset
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = {!front_q, wr_addr};
        ram_wdata = wr_data;
        if (state_q == CLEAR) begin
            ram_we    = rst_n;
            ram_waddr = {!front_q, cnt_q};
            ram_wdata = color_q;
        end else if (wr_accept) begin
            ram_we    = rst_n;
        end
        ram_raddr = {front_q, rd_addr};
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            color_q <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            front_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            front_q <= front_d;
            pend_q  <= pend_d;
        end
    end

    fb_dp_ram #(
        .DEPTH (RAM_DEPTH),
        .WIDTH (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .rd_en (rd_in_range),
        .raddr (ram_raddr),
        .rdata (rd_data)
    );

    assign wr_ready     = ready_q;
    assign clear_busy   = busy_q;
    assign swap_pending = pend_q;
    assign front_page   = front_q;

endmodule

// File: tb/tb_frame_buffer_dbl.sv
// Directed plus randomized bench for frame_buffer_dbl, checked every cycle
// against a page-array model of the frame store.
module tb_frame_buffer_dbl;

    localparam int unsigned W     = 96;
    localparam int unsigned H     = 64;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = W * H;
    localparam int unsigned AW    = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          clear_start;
    logic [DW-1:0] clear_color;
    logic          clear_busy;
    logic          swap_req;
    logic          frame_sync;
    logic          swap_pending;
    logic          front_page;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: two pages of pixels plus the visible control state
    logic [DW-1:0] m_mem [2][DEPTH];
    logic          m_front;
    logic          m_pend;
    logic          m_busy;
    int unsigned   m_filled;
    logic [DW-1:0] m_color;
    logic [DW-1:0] m_rd;

    always #5 clk = ~clk;

    frame_buffer_dbl #(
        .WIDTH  (W),
        .HEIGHT (H),
        .DATA_W (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .clear_start  (clear_start),
        .clear_color  (clear_color),
        .clear_busy   (clear_busy),
        .swap_req     (swap_req),
        .frame_sync   (frame_sync),
        .swap_pending (swap_pending),
        .front_page   (front_page)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        logic [DW-1:0] rd_next;
        logic          back;
        logic          swap_now;
        if (!rst_n) begin
            m_front  = 1'b0;
            m_pend   = 1'b0;
            m_busy   = 1'b0;
            m_filled = 0;
            m_rd     = '0;
        end else begin
            rd_next  = (32'(rd_addr) < DEPTH) ? m_mem[m_front][rd_addr] : '0;
            back     = !m_front;
            swap_now = frame_sync && (m_pend || swap_req) && !m_busy;
            if (wr_en && !m_busy && 32'(wr_addr) < DEPTH)
                m_mem[back][wr_addr] = wr_data;
            if (m_busy) begin
                m_mem[back][m_filled] = m_color;
                m_filled++;
                if (m_filled == DEPTH) m_busy = 1'b0;
            end else if (clear_start) begin
                m_busy   = 1'b1;
                m_filled = 0;
                m_color  = clear_color;
            end
            if (swap_now) begin
                m_front = !m_front;
                m_pend  = 1'b0;
            end else if (swap_req) begin
                m_pend = 1'b1;
            end
            m_rd = rd_next;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("rd_data", rd_data, m_rd);
        chk("front_page", front_page, m_front);
        chk("swap_pending", swap_pending, m_pend);
        chk("clear_busy", clear_busy, m_busy);
        chk("wr_ready", wr_ready, !m_busy);
    endtask

    task automatic idle_inputs();
        wr_en       = 1'b0;
        clear_start = 1'b0;
        swap_req    = 1'b0;
        frame_sync  = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int p = 0; p < 2; p++)
            for (int a = 0; a < int'(DEPTH); a++)
                m_mem[p][a] = '0;
        m_front = 1'b0; m_pend = 1'b0; m_busy = 1'b0;
        m_filled = 0; m_color = '0; m_rd = '0;

        rst_n = 1'b0; idle_inputs();
        wr_addr = '0; wr_data = '0; rd_addr = '0; clear_color = '0;

        // Reset state
        repeat (3) cycle();
        chk("reset_front", front_page, 0);
        chk("reset_ready", wr_ready, 1);
        chk("reset_busy", clear_busy, 0);
        chk("reset_pending", swap_pending, 0);
        chk("reset_rd", rd_data, 0);
        rst_n = 1'b1;

        // A write goes to the back page and is invisible on the front page
        wr_en = 1'b1; wr_addr = 5; wr_data = 16'hF800; cycle(); wr_en = 1'b0;
        rd_addr = 5; cycle();
        chk("back_write_hidden", rd_data, 0);

        // Write, request swap, frame_sync two cycles later
        wr_en = 1'b1; wr_addr = 100; wr_data = 16'h07E0; cycle(); wr_en = 1'b0;
        swap_req = 1'b1; cycle(); swap_req = 1'b0;
        chk("pending_set", swap_pending, 1);
        cycle();
        frame_sync = 1'b1; cycle(); frame_sync = 1'b0;
        chk("swap_front", front_page, 1);
        chk("swap_clears_pending", swap_pending, 0);
        rd_addr = 100; cycle();
        chk("read_after_swap", rd_data, 16'h07E0);

        // swap_req together with frame_sync swaps at once, nothing left pending
        swap_req = 1'b1; frame_sync = 1'b1; cycle(); idle_inputs();
        chk("same_cycle_front", front_page, 0);
        chk("same_cycle_pending", swap_pending, 0);
        cycle();
        chk("same_cycle_pending_after", swap_pending, 0);

        // Three requests merge into one swap
        repeat (3) begin
            swap_req = 1'b1; cycle(); swap_req = 1'b0; cycle();
        end
        frame_sync = 1'b1; cycle(); frame_sync = 1'b0;
        chk("merged_swap", front_page, 1);
        frame_sync = 1'b1; cycle(); frame_sync = 1'b0;
        chk("merged_single_toggle", front_page, 1);

        // Full clear with white; writes dropped, swap blocked while busy
        clear_color = 16'hFFFF; clear_start = 1'b1; cycle();
        clear_start = 1'b0; clear_color = '0;
        chk("clear_busy_rise", clear_busy, 1);
        n = 0;
        while (clear_busy === 1'b1 && n < 7000) begin
            wr_en       = 1'($urandom_range(0, 1));
            wr_addr     = AW'($urandom_range(0, DEPTH - 1));
            wr_data     = DW'($urandom);
            rd_addr     = AW'($urandom_range(0, DEPTH - 1));
            swap_req    = (n == 50);
            frame_sync  = (n == 60 || n == 3000);
            clear_start = (n == 10);
            cycle();
            n++;
        end
        idle_inputs();
        chk("clear_busy_cycles", n, DEPTH);
        chk("no_swap_during_clear", front_page, 1);
        chk("pending_held", swap_pending, 1);
        frame_sync = 1'b1; cycle(); frame_sync = 1'b0;
        chk("swap_after_clear", front_page, 0);
        rd_addr = 0;    cycle(); chk("clear_px0", rd_data, 16'hFFFF);
        rd_addr = 3000; cycle(); chk("clear_px3000", rd_data, 16'hFFFF);
        rd_addr = 6143; cycle(); chk("clear_px6143", rd_data, 16'hFFFF);

        // Out-of-range write dropped, out-of-range read returns zero
        wr_en = 1'b1; wr_addr = 13'd6144; wr_data = 16'h1234; cycle(); wr_en = 1'b0;
        swap_req = 1'b1; frame_sync = 1'b1; cycle(); idle_inputs();
        rd_addr = 0; cycle();
        chk("oob_write_dropped", rd_data, 0);
        rd_addr = 13'd7000; cycle();
        chk("oob_read_zero", rd_data, 0);

        // Randomized traffic without clears
        for (int i = 0; i < 600; i++) begin
            wr_en      = 1'($urandom_range(0, 1));
            wr_addr    = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH, 8191))
                                                     : AW'($urandom_range(0, DEPTH - 1));
            wr_data    = DW'($urandom);
            rd_addr    = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH, 8191))
                                                     : AW'($urandom_range(0, 255));
            swap_req   = ($urandom_range(0, 15) == 0);
            frame_sync = ($urandom_range(0, 19) == 0);
            if (i % 3 == 0) wr_addr = AW'($urandom_range(0, 255));
            cycle();
        end
        idle_inputs();

        // Reset during a clear: front must be page 1 so the clear targets page 0
        if (m_front !== 1'b1) begin
            swap_req = 1'b1; frame_sync = 1'b1; cycle(); idle_inputs();
        end
        chk("pre_abort_front", front_page, 1);
        wr_en = 1'b1; wr_addr = 200; wr_data = 16'hABCD; cycle();
        wr_addr = 50; wr_data = 16'h1111; cycle(); wr_en = 1'b0;
        clear_color = 16'h0F0F; clear_start = 1'b1; cycle(); clear_start = 1'b0;
        repeat (100) cycle();
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        chk("abort_busy", clear_busy, 0);
        chk("abort_ready", wr_ready, 1);
        chk("abort_front", front_page, 0);
        rd_addr = 50;  cycle(); chk("abort_px50", rd_data, 16'h0F0F);
        rd_addr = 99;  cycle(); chk("abort_px99", rd_data, 16'h0F0F);
        rd_addr = 200; cycle(); chk("abort_px200", rd_data, 16'hABCD);
        rd_addr = 100; cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
